serial_frame_ctrl: RTL

Control unit for the lab 2 serial demultiplexer. It watches the serial input for a start bit, then captures a 2-bit port number and a 4-bit data count. It routes the following N data bits to one of four output ports and issues the shift, load and count strobes that drive the neighbouring datapath stages (port/data-number shift registers, transfer counter, SSD). It holds its own header and data counters, so it is verifiable standalone.

---
 rtl/serial_frame_ctrl_if.sv | 28 ++
 rtl/serial_frame_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/serial_frame_ctrl_if.sv
// Bus between the serial frame controller and its datapath neighbours.
// The master side is the controller itself.
interface serial_frame_ctrl_if;
  logic       clk_en;
  logic       serin;
  logic       port_sh_en;
  logic       num_sh_en;
  logic       ld_cnt;
  logic       cnt_en;
  logic [1:0] port;
  logic [3:0] num_data;
  logic [3:0] p_out;
  logic [3:0] p_valid;
  logic       busy;
  logic       done;

  modport master (
    input  clk_en, serin,
    output port_sh_en, num_sh_en, ld_cnt, cnt_en,
    output port, num_data, p_out, p_valid, busy, done
  );

  modport slave (
    output clk_en, serin,
    input  port_sh_en, num_sh_en, ld_cnt, cnt_en,
    input  port, num_data, p_out, p_valid, busy, done
  );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Serial demux control: detects a start bit, captures a 2-bit port and 4-bit
// count, then routes the following data bits to the selected output port.
module serial_frame_ctrl (
  input  logic                clk,
  input  logic                rst,
  serial_frame_ctrl_if.master bus
);
  localparam int unsigned PORT_W = 2;
  localparam int unsigned NUM_W  = 4;
  localparam int unsigned HDR_W  = 3;

  typedef enum logic [2:0] {IDLE, PORT, NUM, DATA, DONE} state_t;

  state_t             state;
  logic [HDR_W-1:0]   hdr_cnt;
  logic [NUM_W-1:0]   data_cnt;
  logic [PORT_W-1:0]  port_q;
  logic [NUM_W-1:0]   num_q;
  logic [NUM_W-1:0]   num_next;
  logic               hdr_last;

  assign num_next = {num_q[NUM_W-2:0], bus.serin};

  // The header counter ends a field after PORT_W port bits or NUM_W count bits.
  always_comb begin
    hdr_last = 1'b0;
    if (state == PORT) hdr_last = (hdr_cnt == HDR_W'(PORT_W - 1));
    if (state == NUM)  hdr_last = (hdr_cnt == HDR_W'(NUM_W - 1));
  end

  // Frame sequencing; every register holds while clk_en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hdr_cnt  <= '0;
      data_cnt <= '0;
      port_q   <= '0;
      num_q    <= '0;
    end else if (bus.clk_en) begin
      case (state)
        IDLE: begin
          hdr_cnt <= '0;
          if (!bus.serin) state <= PORT;
        end
        PORT: begin
          port_q <= {port_q[0], bus.serin};
          if (hdr_last) begin
            hdr_cnt <= '0;
            state   <= NUM;
          end else begin
            hdr_cnt <= hdr_cnt + HDR_W'(1);
          end
        end
        NUM: begin
          num_q <= num_next;
          if (hdr_last) begin
            hdr_cnt  <= '0;
            data_cnt <= num_next;
            state    <= (num_next == '0) ? DONE : DATA;
          end else begin
            hdr_cnt <= hdr_cnt + HDR_W'(1);
          end
        end
        DATA: begin
          data_cnt <= data_cnt - NUM_W'(1);
          if (data_cnt == NUM_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.port     = port_q;
  assign bus.num_data = num_q;
  assign bus.busy     = (state != IDLE);

  // Strobes and routing are state decodes qualified by clk_en, so a disabled
  // cycle never produces a strobe or a valid bit.
  always_comb begin
    bus.port_sh_en = 1'b0;
    bus.num_sh_en  = 1'b0;
    bus.ld_cnt     = 1'b0;
    bus.cnt_en     = 1'b0;
    bus.done       = 1'b0;
    bus.p_out      = '0;
    bus.p_valid    = '0;
    if (bus.clk_en) begin
      case (state)
        PORT: bus.port_sh_en = 1'b1;
        NUM: begin
          bus.num_sh_en = 1'b1;
          bus.ld_cnt    = hdr_last;
        end
        DATA: begin
          bus.cnt_en          = 1'b1;
          bus.p_valid[port_q] = 1'b1;
          bus.p_out[port_q]   = bus.serin;
        end
        DONE:    bus.done = 1'b1;
        default: ;
      endcase
    end
  end
endmodule
